// File: rtl/bbqm_event_conditioner.sv
// Button conditioner: 2-flop sync, tick-sampled debounce, one pulse per press, depart-first ordering.
// Optional auto-repeat while a button is held is enabled by defining BBQM_AUTOREPEAT_EN.
module bbqm_event_conditioner #(
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned REPEAT_TICKS   = 500
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_arrive,
    input  logic btn_depart,
    input  logic full,
    input  logic empty,
    output logic arrive_pulse,
    output logic depart_pulse,
    output logic reject_pulse,
    output logic arrive_level,
    output logic depart_level
);
    localparam int unsigned TW  = $clog2(TICK_DIV + 1);
    localparam int unsigned DW  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned NCH = 2;
    localparam int unsigned ARR = 0;
    localparam int unsigned DEP = 1;

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_e;

    logic [NCH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NCH-1:0] sample_q, sample_d, level_q, level_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           tick_c, tick_q;
    state_e         state_q [NCH];
    state_e         state_d [NCH];
    logic [DW-1:0]  cnt_q [NCH];
    logic [DW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] event_c;
    logic           pend_q, pend_d;
    logic           arrive_pulse_q, arrive_pulse_d;
    logic           depart_pulse_q, depart_pulse_d;
    logic           reject_pulse_q, reject_pulse_d;

`ifdef BBQM_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);
    logic [RW-1:0]  rep_q [NCH];
    logic [RW-1:0]  rep_d [NCH];
`else
    // Without auto-repeat the repeat interval has no effect on the logic.
    if (REPEAT_TICKS == 0) begin : g_repeat_unused
    end
`endif

    // Synchroniser, tick generator and tick-aligned sample capture.
    always_comb begin
        sync1_d  = {btn_depart, btn_arrive};
        sync2_d  = sync1_q;
        tick_c   = (tcnt_q == TW'(TICK_DIV - 1));
        tcnt_d   = tick_c ? '0 : tcnt_q + TW'(1);
        sample_d = tick_c ? sync2_q : sample_q;
    end

    // Per-channel debounce FSM; acts on the sample captured by the previous tick.
    always_comb begin
        event_c = '0;
        level_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
`ifdef BBQM_AUTOREPEAT_EN
            rep_d[i]   = rep_q[i];
`endif
            if (tick_q) begin
                unique case (state_q[i])
                    IDLE: begin
                        if (sample_q[i]) begin
                            if (DW'(1) >= DW'(DEBOUNCE_TICKS)) begin
                                state_d[i] = HELD;
                                cnt_d[i]   = '0;
                                event_c[i] = 1'b1;
`ifdef BBQM_AUTOREPEAT_EN
                                rep_d[i]   = '0;
`endif
                            end else begin
                                state_d[i] = PRESS_CHK;
                                cnt_d[i]   = DW'(1);
                            end
                        end
                    end
                    PRESS_CHK: begin
                        if (!sample_q[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] + DW'(1) >= DW'(DEBOUNCE_TICKS)) begin
                            state_d[i] = HELD;
                            cnt_d[i]   = '0;
                            event_c[i] = 1'b1;
`ifdef BBQM_AUTOREPEAT_EN
                            rep_d[i]   = '0;
`endif
                        end else begin
                            cnt_d[i] = cnt_q[i] + DW'(1);
                        end
                    end
                    HELD: begin
                        if (!sample_q[i]) begin
                            state_d[i] = (DW'(1) >= DW'(DEBOUNCE_TICKS)) ? IDLE : REL_CHK;
                            cnt_d[i]   = (DW'(1) >= DW'(DEBOUNCE_TICKS)) ? '0 : DW'(1);
`ifdef BBQM_AUTOREPEAT_EN
                            rep_d[i]   = '0;
                        end else if (rep_q[i] + RW'(1) >= RW'(REPEAT_TICKS)) begin
                            rep_d[i]   = '0;
                            event_c[i] = 1'b1;
                        end else begin
                            rep_d[i]   = rep_q[i] + RW'(1);
`endif
                        end
                    end
                    REL_CHK: begin
                        if (sample_q[i]) begin
                            state_d[i] = HELD;
                            cnt_d[i]   = '0;
`ifdef BBQM_AUTOREPEAT_EN
                            rep_d[i]   = '0;
`endif
                        end else if (cnt_q[i] + DW'(1) >= DW'(DEBOUNCE_TICKS)) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + DW'(1);
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            level_d[i] = (state_d[i] == HELD) || (state_d[i] == REL_CHK);
        end
    end

    // Issue: depart wins a tie, arrive waits one cycle in the pending flag.
    always_comb begin
        arrive_pulse_d = 1'b0;
        depart_pulse_d = 1'b0;
        reject_pulse_d = 1'b0;
        pend_d         = pend_q;
        if (event_c[DEP]) begin
            depart_pulse_d = !empty;
            reject_pulse_d = empty;
            pend_d         = event_c[ARR];
        end else if (event_c[ARR]) begin
            arrive_pulse_d = !full;
            reject_pulse_d = full;
        end else if (pend_q) begin
            arrive_pulse_d = !full;
            reject_pulse_d = full;
            pend_d         = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            sample_q       <= '0;
            level_q        <= '0;
            tcnt_q         <= '0;
            tick_q         <= 1'b0;
            pend_q         <= 1'b0;
            arrive_pulse_q <= 1'b0;
            depart_pulse_q <= 1'b0;
            reject_pulse_q <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
`ifdef BBQM_AUTOREPEAT_EN
                rep_q[i]   <= '0;
`endif
            end
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sample_q       <= sample_d;
            level_q        <= level_d;
            tcnt_q         <= tcnt_d;
            tick_q         <= tick_c;
            pend_q         <= pend_d;
            arrive_pulse_q <= arrive_pulse_d;
            depart_pulse_q <= depart_pulse_d;
            reject_pulse_q <= reject_pulse_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef BBQM_AUTOREPEAT_EN
                rep_q[i]   <= rep_d[i];
`endif
            end
        end
    end

    assign arrive_pulse = arrive_pulse_q;
    assign depart_pulse = depart_pulse_q;
    assign reject_pulse = reject_pulse_q;
    assign arrive_level = level_q[ARR];
    assign depart_level = level_q[DEP];
endmodule

// File: tb/tb_bbqm_event_conditioner.sv
// Bench for bbqm_event_conditioner: scenario tasks plus random presses against a run-length/queue model.
module tb_bbqm_event_conditioner;
    localparam int TD = 4;
    localparam int DT = 3;
    localparam int RT = 5;
    localparam int LAT_MIN = 2 + TD * (DT - 1) + 2;
    localparam int LAT_MAX = 2 + TD * DT + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_arrive = 1'b0, btn_depart = 1'b0, full = 1'b0, empty = 1'b0;
    logic arrive_pulse, depart_pulse, reject_pulse, arrive_level, depart_level;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    bbqm_event_conditioner #(.TICK_DIV(TD), .DEBOUNCE_TICKS(DT), .REPEAT_TICKS(RT)) dut (
        .clk(clk), .reset(reset), .btn_arrive(btn_arrive), .btn_depart(btn_depart),
        .full(full), .empty(empty), .arrive_pulse(arrive_pulse), .depart_pulse(depart_pulse),
        .reject_pulse(reject_pulse), .arrive_level(arrive_level), .depart_level(depart_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a level flips after DT consecutive tick samples of the other value;
    // accepted presses (and repeats) enter an ordered queue, one entry issued per cycle.
    bit [1:0] m_s1, m_s2, m_smp, m_lvl, m_btn, m_ev;
    int       m_run [2];
    int       m_rep [2];
    int       m_tcnt;
    bit       m_tickd, m_tick_now;
    int       m_q [$];
    int       m_e;
    bit       exp_arr, exp_dep, exp_rej;
    logic [4:0] obs_vec, exp_vec;

    assign obs_vec = {arrive_pulse, depart_pulse, reject_pulse, arrive_level, depart_level};
    assign exp_vec = {exp_arr, exp_dep, exp_rej, m_lvl[0], m_lvl[1]};

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_s1 = '0; m_s2 = '0; m_smp = '0; m_lvl = '0; m_tcnt = 0; m_tickd = 0;
                m_run[0] = 0; m_run[1] = 0; m_rep[0] = 0; m_rep[1] = 0;
                m_q.delete();
                exp_arr = 0; exp_dep = 0; exp_rej = 0;
            end else begin
                m_btn = {btn_depart, btn_arrive};
                m_tick_now = (m_tcnt == TD - 1);
                m_ev = '0;
                if (m_tickd) begin
                    for (int ch = 0; ch < 2; ch++) begin
                        if (m_smp[ch] != m_lvl[ch]) begin
                            m_rep[ch] = 0;
                            m_run[ch]++;
                            if (m_run[ch] >= DT) begin
                                m_lvl[ch] = m_smp[ch];
                                m_run[ch] = 0;
                                if (m_lvl[ch]) m_ev[ch] = 1'b1;
                            end
                        end else begin
                            if (m_run[ch] != 0) m_rep[ch] = 0;
                            else if (m_lvl[ch]) begin
`ifdef BBQM_AUTOREPEAT_EN
                                m_rep[ch]++;
                                if (m_rep[ch] == RT) begin
                                    m_rep[ch] = 0;
                                    m_ev[ch] = 1'b1;
                                end
`endif
                            end
                            m_run[ch] = 0;
                        end
                    end
                end
                if (m_ev[1]) m_q.push_back(1);
                if (m_ev[0]) m_q.push_back(0);
                exp_arr = 0; exp_dep = 0; exp_rej = 0;
                if (m_q.size() > 0) begin
                    m_e = m_q.pop_front();
                    if (m_e == 0) begin
                        if (full) exp_rej = 1; else exp_arr = 1;
                    end else begin
                        if (empty) exp_rej = 1; else exp_dep = 1;
                    end
                end
                if (m_tick_now) m_smp = m_s2;
                m_s2 = m_s1;
                m_s1 = m_btn;
                m_tickd = m_tick_now;
                m_tcnt = m_tick_now ? 0 : m_tcnt + 1;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== 5'b0) $display("FAIL reset_outputs cyc=%0d got=%b want=00000", cyc, obs_vec);
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    task automatic test_single_arrive();
        int c0, npulse, first;
        npulse = 0; first = -1;
        @(negedge clk);
        btn_arrive = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL single_model cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec);
            else n_pass++;
            if (arrive_pulse) begin
                npulse++;
                if (first < 0) first = cyc;
            end
        end
        n_checks++;
        if (first - c0 < LAT_MIN || first - c0 > LAT_MAX)
            $display("FAIL single_latency got=%0d want=%0d..%0d", first - c0, LAT_MIN, LAT_MAX);
        else n_pass++;
        n_checks++;
        if (arrive_level !== 1'b1) $display("FAIL single_level got=%b want=1", arrive_level);
        else n_pass++;
`ifndef BBQM_AUTOREPEAT_EN
        n_checks++;
        if (npulse != 1) $display("FAIL single_count got=%0d want=1", npulse);
        else n_pass++;
`endif
        btn_arrive = 1'b0;
        npulse = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL release_model cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec);
            else n_pass++;
            if (arrive_pulse || depart_pulse || reject_pulse) npulse++;
        end
        n_checks++;
        if (npulse != 0 || arrive_level !== 1'b0)
            $display("FAIL release_quiet got=%0d pulses level=%b want=0 pulses level=0", npulse, arrive_level);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int npulse, lvl_seen;
        npulse = 0; lvl_seen = 0;
        @(negedge clk);
        btn_depart = 1'b1;
        for (int i = 0; i < 46; i++) begin
            @(negedge clk);
            if (i == 5) btn_depart = 1'b0;
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL glitch_model cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec);
            else n_pass++;
            if (depart_pulse || reject_pulse) npulse++;
            if (depart_level) lvl_seen++;
        end
        n_checks++;
        if (npulse != 0 || lvl_seen != 0)
            $display("FAIL glitch_reject got=%0d pulses %0d level-cycles want=0 0", npulse, lvl_seen);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int dcyc, acyc, both, nd, na;
        dcyc = -1; acyc = -1; both = 0; nd = 0; na = 0;
        @(negedge clk);
        btn_arrive = 1'b1;
        btn_depart = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 40) begin
                btn_arrive = 1'b0;
                btn_depart = 1'b0;
            end
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL simul_model cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec);
            else n_pass++;
            if (arrive_pulse && depart_pulse) both++;
            if (depart_pulse) begin nd++; if (dcyc < 0) dcyc = cyc; end
            if (arrive_pulse) begin na++; if (acyc < 0) acyc = cyc; end
        end
        n_checks++;
        if (dcyc < 0 || acyc != dcyc + 1)
            $display("FAIL simul_order got=dep@%0d arr@%0d want=arr one cycle after dep", dcyc, acyc);
        else n_pass++;
        n_checks++;
        if (both != 0) $display("FAIL simul_exclusive got=%0d overlaps want=0", both);
        else n_pass++;
`ifndef BBQM_AUTOREPEAT_EN
        n_checks++;
        if (nd != 1 || na != 1) $display("FAIL simul_count got=dep %0d arr %0d want=1 1", nd, na);
        else n_pass++;
`endif
    endtask

    task automatic test_full_empty();
        int nrej, nok;
        for (int pass = 0; pass < 2; pass++) begin
            nrej = 0; nok = 0;
            @(negedge clk);
            if (pass == 0) begin full = 1'b1; btn_arrive = 1'b1; end
            else begin empty = 1'b1; btn_depart = 1'b1; end
            for (int i = 0; i < 65; i++) begin
                @(negedge clk);
                if (i == 24) begin btn_arrive = 1'b0; btn_depart = 1'b0; end
                n_checks++;
                if (obs_vec !== exp_vec) $display("FAIL flag_model cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec);
                else n_pass++;
                if (reject_pulse) nrej++;
                if (arrive_pulse || depart_pulse) nok++;
            end
            n_checks++;
            if (nrej != 1 || nok != 0)
                $display("FAIL flag_reject pass=%0d got=rej %0d ok %0d want=1 0", pass, nrej, nok);
            else n_pass++;
            full = 1'b0;
            empty = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int r, first, npulse;
        first = -1; npulse = 0;
        @(negedge clk);
        btn_arrive = 1'b1;
        repeat (6) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL rstmid_model cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec);
            else n_pass++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== 5'b0) $display("FAIL rstmid_zero cyc=%0d got=%b want=00000", cyc, obs_vec);
            else n_pass++;
        end
        reset = 1'b0;
        r = cyc;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (i == 30) btn_arrive = 1'b0;
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL rstmid_model cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec);
            else n_pass++;
            if (arrive_pulse) begin npulse++; if (first < 0) first = cyc; end
        end
        n_checks++;
        if (first - r < LAT_MIN || first - r > LAT_MAX)
            $display("FAIL rstmid_latency got=%0d want=%0d..%0d", first - r, LAT_MIN, LAT_MAX);
        else n_pass++;
    endtask

    task automatic test_random();
        int dur [2];
        dur[0] = 0; dur[1] = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec);
            else n_pass++;
            if (dur[0] == 0) begin btn_arrive = 1'($urandom_range(0, 1)); dur[0] = $urandom_range(1, 24); end
            else dur[0]--;
            if (dur[1] == 0) begin btn_depart = 1'($urandom_range(0, 1)); dur[1] = $urandom_range(1, 24); end
            else dur[1]--;
            if ($urandom_range(0, 15) == 0) full = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) empty = 1'($urandom_range(0, 1));
        end
        btn_arrive = 1'b0; btn_depart = 1'b0; full = 1'b0; empty = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL random_tail cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec);
            else n_pass++;
        end
    endtask

`ifdef BBQM_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int last, npulse, bad_gap;
        last = -1; npulse = 0; bad_gap = 0;
        @(negedge clk);
        btn_arrive = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL repeat_model cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec);
            else n_pass++;
            if (arrive_pulse) begin
                if (last >= 0 && cyc - last != TD * RT) bad_gap++;
                last = cyc;
                npulse++;
            end
        end
        n_checks++;
        if (npulse < 2 || bad_gap != 0)
            $display("FAIL repeat_spacing got=%0d pulses %0d bad gaps want>=2 pulses 0 bad gaps", npulse, bad_gap);
        else n_pass++;
        btn_arrive = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL repeat_release cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_arrive();
        test_glitch();
        test_simultaneous();
        test_full_empty();
        test_reset_mid();
`ifdef BBQM_AUTOREPEAT_EN
        test_autorepeat();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
